lfsr_arbiter: RTL

Round-robin scheduler that shares a single SIZE-bit LFSR random source between N_REQ requesters. Each grant advances the LFSR by STEPS clocks so consecutive draws are decorrelated. The word is then delivered over a valid/ready handshake tagged with a one-hot grant. Seed and tap are reloaded through a configuration port. The block sits between the team's LFSR datapath rule and the consumer blocks that need random words: scramblers, test pattern generators and backoff timers.

---
 rtl/lfsr_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter handing out words from one shared Galois-style LFSR.
// Each grant runs the LFSR STEPS clocks, then offers the word on a valid/ready port.
module lfsr_arbiter #(
    parameter int              SIZE     = 8,
    parameter int              N_REQ    = 4,
    parameter int              STEPS    = 8,
    parameter logic [SIZE-1:0] RST_SEED = SIZE'(8'h01),
    parameter logic [SIZE-1:0] RST_TAP  = SIZE'(8'h1D)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] out_grant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_data,
    input  logic             cfg_load,
    input  logic [SIZE-1:0]  cfg_seed,
    input  logic [SIZE-1:0]  cfg_tap,
    output logic             cfg_err,
    output logic             busy,
    output logic [15:0]      draw_count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_DELIVER
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SIZE-1:0]    r_lfsr;
    logic [SIZE-1:0]    r_tap;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_gidx;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_REQ-1:0]   r_grant;
    logic [SIZE-1:0]    r_data;
    logic               r_cfg_err;
    logic [15:0]        r_draw_count;
    logic               w_found;
    logic [PTR_W-1:0]   w_pick;
    logic [PTR_W-1:0]   w_k;
    logic [SIZE-1:0]    w_lfsr_next;

    // The all-zero-low-bits term lets the register escape the all-zero lockup state.
    function automatic logic [SIZE-1:0] f_step(input logic [SIZE-1:0] s, input logic [SIZE-1:0] t);
        logic fb;
        fb = s[SIZE-1] ^ (s[SIZE-2:0] == '0);
        return {s[SIZE-2:0], fb} ^ (t & {{(SIZE-1){fb}}, 1'b0});
    endfunction

    function automatic logic [SIZE-1:0] f_sanitize(input logic [SIZE-1:0] t);
        return (t == '0 || t == '1) ? SIZE'(2) : t;
    endfunction

    assign w_lfsr_next = f_step(r_lfsr, r_tap);

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_k = PTR_W'((int'(r_ptr) + i) % N_REQ);
            if (!w_found && req[w_k]) begin
                w_found = 1'b1;
                w_pick  = w_k;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_load)
                    w_next = S_LOAD;
                else if (w_found)
                    w_next = S_STEP;
            end
            S_LOAD:    w_next = S_IDLE;
            S_STEP:    if (r_cnt == '0) w_next = S_DELIVER;
            S_DELIVER: if (out_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr       <= RST_SEED;
            r_tap        <= f_sanitize(RST_TAP);
            r_ptr        <= '0;
            r_gidx       <= '0;
            r_cnt        <= '0;
            r_grant      <= '0;
            r_data       <= '0;
            r_cfg_err    <= 1'b0;
            r_draw_count <= '0;
        end else begin
            r_cfg_err <= cfg_load && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (cfg_load) begin
                        r_lfsr <= cfg_seed;
                        r_tap  <= f_sanitize(cfg_tap);
                    end else if (w_found) begin
                        r_grant <= N_REQ'(1) << w_pick;
                        r_gidx  <= w_pick;
                        r_cnt   <= CNT_W'(STEPS - 1);
                    end
                end
                S_STEP: begin
                    r_lfsr <= w_lfsr_next;
                    if (r_cnt == '0)
                        r_data <= w_lfsr_next;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_DELIVER: begin
                    if (out_ready) begin
                        r_draw_count <= r_draw_count + 16'd1;
                        r_ptr        <= (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
                        r_grant      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_grant  = r_grant;
    assign out_valid  = (r_state == S_DELIVER);
    assign out_data   = r_data;
    assign cfg_err    = r_cfg_err;
    assign busy       = (r_state != S_IDLE);
    assign draw_count = r_draw_count;

endmodule
